// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: state encoding and the default
// address/data widths that the PC and program RAM are built with.
package program_loader_pkg;

  // Widths shared with the program counter and the 16-word RAM.
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  // Fixed 3-bit state codes, kept stable so debug probes decode them the same way.
  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_WAIT   = 3'd1;
  localparam logic [2:0] ENC_WRITE  = 3'd2;
  localparam logic [2:0] ENC_REWIND = 3'd3;
  localparam logic [2:0] ENC_DONE   = 3'd4;

  typedef enum logic [2:0] {
    LD_IDLE   = ENC_IDLE,
    LD_WAIT   = ENC_WAIT,
    LD_WRITE  = ENC_WRITE,
    LD_REWIND = ENC_REWIND,
    LD_DONE   = ENC_DONE
  } state_t;

endpackage

// File: rtl/program_loader.sv
// Program loader: takes program words over a valid/ready handshake, writes
// them to RAM through the PC parallel-load path, rewinds the PC to 0 at the
// end and holds the CPU off for the whole load. All outputs come from flops
// that are decoded from the next state, so they are glitch-free and drop
// immediately on an asynchronous RESET.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] addr_out,
  output logic              load,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   loaded_count
);

  // Final address of a full load; the address counter stops here and never wraps.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W:0]     count_q, count_d;

  logic                in_ready_q, in_ready_d;
  logic                ram_we_q, ram_we_d;
  logic                load_q, load_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_out_q, addr_out_d;

  // Next-state, address counter, data capture and loaded-word count.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      LD_IDLE: begin
        if (start) begin
          state_d = LD_WAIT;
          addr_d  = {ADDR_W{1'b0}};
          count_d = {(ADDR_W+1){1'b0}};
        end else begin
          state_d = LD_IDLE;
        end
      end
      LD_WAIT: begin
        // abort wins over a simultaneous word; that word is not taken.
        if (abort) begin
          state_d = LD_REWIND;
        end else if (in_valid) begin
          state_d = LD_WRITE;
          data_d  = in_data;
        end else begin
          state_d = LD_WAIT;
        end
      end
      LD_WRITE: begin
        // The write happens this cycle regardless; only the follow-on changes.
        count_d = count_q + CNT_ONE;
        if ((addr_q == LAST_ADDR) || abort) begin
          state_d = LD_REWIND;
        end else begin
          state_d = LD_WAIT;
          addr_d  = addr_q + ADDR_ONE;
        end
      end
      LD_REWIND: begin
        state_d = LD_DONE;
      end
      LD_DONE: begin
        state_d = LD_IDLE;
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  // Output decode from the next state so each output is a plain flop.
  always_comb begin
    in_ready_d = 1'b0;
    ram_we_d   = 1'b0;
    load_d     = 1'b0;
    done_d     = 1'b0;
    busy_d     = 1'b0;
    addr_out_d = {ADDR_W{1'b0}};
    case (state_d)
      LD_IDLE: begin
        busy_d = 1'b0;
      end
      LD_WAIT: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      LD_WRITE: begin
        ram_we_d   = 1'b1;
        load_d     = 1'b1;
        busy_d     = 1'b1;
        addr_out_d = addr_d;
      end
      LD_REWIND: begin
        // PC parallel-loads address 0 so the CPU restarts at the program head.
        load_d = 1'b1;
        busy_d = 1'b1;
      end
      LD_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared immediately by RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= LD_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      count_q <= {(ADDR_W+1){1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // Output registers; RESET drops ram_we, load and cpu_hold without a clock edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      in_ready_q <= 1'b0;
      ram_we_q   <= 1'b0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      addr_out_q <= {ADDR_W{1'b0}};
    end else begin
      in_ready_q <= in_ready_d;
      ram_we_q   <= ram_we_d;
      load_q     <= load_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      addr_out_q <= addr_out_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign ram_we       = ram_we_q;
  assign load         = load_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign cpu_hold     = busy_q;
  assign addr_out     = addr_out_q;
  assign ram_data     = data_q;
  assign loaded_count = count_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Front-panel/programmer-side loader that writes a program into the 16-word RAM and drives the program counter's load path.
- Accepts words over a valid/ready byte handshake from the programming interface.
- Presents each word's address on the PC parallel-load bus (addr_out to PC_in, load to load) and pulses the RAM write strobe.
- When loading finishes, rewinds the PC to address 0.
- Holds the CPU off (cpu_hold, which drives the PC en gate) for the whole load.

Parameters:
ADDR_W, 4, address width; matches PC width.
DATA_W, 8, RAM word width.
DEPTH, 16, words per full load; 1 <= DEPTH <= 2**ADDR_W.

Ports:
CLK  in  1  clock; all state changes on the rising edge.
RESET  in  1  asynchronous, active-high reset.
start  in  1  begin a load; sampled only in IDLE.
abort  in  1  terminate the load early; sampled in WAIT and WRITE.
in_valid  in  1  in_data holds a word.
in_data  in  DATA_W  program word.
in_ready  out  1  loader can accept a word.
addr_out  out  ADDR_W  address to PC_in and RAM address mux.
load  out  1  PC parallel-load strobe.
ram_data  out  DATA_W  write data to RAM.
ram_we  out  1  RAM write strobe.
cpu_hold  out  1  high while busy; gates PC en low.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse at end of a load.
loaded_count  out  ADDR_W+1  words written in the current or last load.

Behaviour:
- States: IDLE, WAIT, WRITE, REWIND, DONE. Outputs are Moore-decoded from state and registers.
- On RESET (asynchronous, immediate):
  - state=IDLE.
  - Address counter = 0, data register = 0, loaded_count = 0.
  - All outputs 0; ram_we and load drop without waiting for a clock edge.
- IDLE: in_ready=0, cpu_hold=0. When start=1, go to WAIT; clear the address counter and loaded_count.
- WAIT: in_ready=1, cpu_hold=1.
  - abort=1: go to REWIND. abort has priority over in_valid; that word is not accepted.
  - else in_valid=1: capture in_data into the data register, go to WRITE.
- WRITE: in_ready=0, ram_we=1, load=1, addr_out=addr counter, ram_data=data register; loaded_count increments at the exiting edge.
  - If addr==DEPTH-1 or abort=1: go to REWIND. The write still occurs this cycle.
  - Else: addr+1, go to WAIT.
- REWIND: load=1, ram_we=0, addr_out=0, which returns the PC to 0. Go to DONE.
- DONE: done=1, cpu_hold=1. Go to IDLE. cpu_hold drops the following cycle.
- Latency and throughput:
  - A handshake accepted at edge k gives ram_we=1 in cycle k+1.
  - Maximum throughput is 1 word per 2 cycles.
- Address counter: ADDR_W bits, never wraps. The terminal test is DEPTH-1, so with DEPTH=16 the last write is to address 15.
- loaded_count: ADDR_W+1 bits, so a full load of 16 reads 5'b10000. It holds its value after DONE until the next start.
- addr_out is 0 and ram_data is held at its last value whenever neither load nor ram_we is asserted.
- start outside IDLE is ignored. abort in IDLE, REWIND or DONE is ignored.
- A RESET mid-load leaves the RAM partially written; the loader does not recover it.

Decomposition:
- Shared package/header holds:
  - State encoding localparams (3-bit: IDLE=0, WAIT=1, WRITE=2, REWIND=3, DONE=4).
  - Default ADDR_W and DATA_W constants, shared with the PC and RAM.
- No sub-module. The address counter and loaded_count are inline registers; a separate counter module would duplicate the PC.

Test Plan:
- Full load with in_valid held high and data 8'hA0+i → ram_we at addr 0..15 every 2nd cycle with ram_data = A0..AF; then a REWIND cycle (load=1, addr_out=0); done pulses once; loaded_count=16; cpu_hold high from the cycle after start through DONE.
- Back-pressure: drop in_valid for 3 cycles between word 2 and word 3 → no ram_we during the gap; in_ready stays 1; the third write lands at addr 2.
- Abort in WAIT after 5 writes → no further ram_we; REWIND follows; done pulses; loaded_count=5. Abort asserted during WRITE of word 7 → that write occurs at addr 6; loaded_count=7.
- start pulsed during WAIT and during DONE → ignored. A new start in IDLE restarts at addr 0 with loaded_count cleared to 0.
- RESET asserted mid-cycle while in WRITE → ram_we, load, cpu_hold and busy go to 0 before the next edge; state=IDLE; a subsequent start performs a clean full load.
- DEPTH=4 build → exactly 4 writes (addr 0..3), then REWIND; loaded_count=4.
